// File: rtl/udp_hdr_builder.sv
// Streaming UDP header generator: counts payload bytes and accumulates the RFC 768
// checksum. The header is valid two cycles after tlast. Holds one packet in flight;
// tready stays low from the fold cycle until the header handshake.
module udp_hdr_builder #(
    parameter int DATA_WIDTH  = 256,
    parameter bit CHECKSUM_EN = 1'b1,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             src_ip,
    input  logic [31:0]             dest_ip,
    input  logic [15:0]             src_port,
    input  logic [15:0]             dest_port,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [63:0]             udp_hdr,
    output logic                    udp_hdr_valid,
    input  logic                    udp_hdr_ready,
    output logic                    udp_hdr_err
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int NWORDS = DATA_WIDTH / 16;
    localparam int PC_W   = $clog2(KEEP_W + 1);
    localparam int CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FOLD  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            src_ip_q, src_ip_d;
    logic [31:0]            dest_ip_q, dest_ip_d;
    logic [15:0]            src_port_q, src_port_d;
    logic [15:0]            dest_port_q, dest_port_d;
    logic [63:0]            hdr_q, hdr_d;
    logic                   err_q, err_d;

    logic                   beat;
    logic                   first_beat;
    logic [PC_W-1:0]        keep_cnt;
    logic [15:0]            word;
    logic [ACC_WIDTH-1:0]   beat_sum;
    logic [15:0]            len_w;
    logic [ACC_WIDTH-1:0]   total;
    logic [ACC_WIDTH-1:0]   fold1;
    logic [16:0]            fold2;
    logic [15:0]            sum16;
    logic [15:0]            csum_raw;
    logic [15:0]            csum_fin;

    assign beat       = s_axis_tvalid && s_axis_tready;
    assign first_beat = beat && (state_q == ST_IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    state_d = s_axis_tlast ? ST_FOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat && s_axis_tlast) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: state_d = ST_OUT;
            ST_OUT: begin
                if (udp_hdr_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_axis_tready = 1'b0;
        udp_hdr_valid = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACCUM: s_axis_tready = 1'b1;
            ST_OUT:            udp_hdr_valid = 1'b1;
            default: begin
                s_axis_tready = 1'b0;
                udp_hdr_valid = 1'b0;
            end
        endcase
    end

    // Byte count and big-endian word sum of one beat; disabled bytes read as zero,
    // which also pads an odd trailing byte.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep_cnt = keep_cnt + PC_W'(s_axis_tkeep[i]);
        end
    end

    always_comb begin
        word     = '0;
        beat_sum = '0;
        for (int w = 0; w < NWORDS; w++) begin
            word[15:8] = s_axis_tkeep[2*w]   ? s_axis_tdata[16*w +: 8]     : 8'h00;
            word[7:0]  = s_axis_tkeep[2*w+1] ? s_axis_tdata[16*w+8 +: 8]   : 8'h00;
            beat_sum   = beat_sum + ACC_WIDTH'(word);
        end
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        src_ip_d    = src_ip_q;
        dest_ip_d   = dest_ip_q;
        src_port_d  = src_port_q;
        dest_port_d = dest_port_q;
        if (first_beat) begin
            acc_d       = beat_sum;
            cnt_d       = CNT_W'(keep_cnt);
            src_ip_d    = src_ip;
            dest_ip_d   = dest_ip;
            src_port_d  = src_port;
            dest_port_d = dest_port;
        end else if (beat) begin
            acc_d = acc_q + beat_sum;
            cnt_d = cnt_q + CNT_W'(keep_cnt);
        end
    end

    // Pseudo-header and UDP header words are added once the length is known.
    assign len_w = cnt_q[15:0] + 16'd8;

    always_comb begin
        total = acc_q
              + ACC_WIDTH'(src_ip_q[31:16])  + ACC_WIDTH'(src_ip_q[15:0])
              + ACC_WIDTH'(dest_ip_q[31:16]) + ACC_WIDTH'(dest_ip_q[15:0])
              + ACC_WIDTH'(16'h0011)
              + ACC_WIDTH'(len_w) + ACC_WIDTH'(len_w)
              + ACC_WIDTH'(src_port_q) + ACC_WIDTH'(dest_port_q);
        fold1    = ACC_WIDTH'(total[15:0]) + (total >> 16);
        fold2    = {1'b0, fold1[15:0]} + 17'(fold1 >> 16);
        sum16    = fold2[15:0] + {15'd0, fold2[16]};
        csum_raw = ~sum16;
        csum_fin = (csum_raw == 16'h0000) ? 16'hFFFF : csum_raw;
    end

    always_comb begin
        hdr_d = hdr_q;
        err_d = err_q;
        if (state_q == ST_FOLD) begin
            hdr_d = {(CHECKSUM_EN ? csum_fin : 16'h0000), len_w, dest_port_q, src_port_q};
            err_d = (cnt_q > CNT_W'(65527));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            src_ip_q    <= '0;
            dest_ip_q   <= '0;
            src_port_q  <= '0;
            dest_port_q <= '0;
            hdr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            src_ip_q    <= src_ip_d;
            dest_ip_q   <= dest_ip_d;
            src_port_q  <= src_port_d;
            dest_port_q <= dest_port_d;
            hdr_q       <= hdr_d;
            err_q       <= err_d;
        end
    end

    assign udp_hdr     = hdr_q;
    assign udp_hdr_err = err_q;

endmodule
